// File: rtl/bus_pkg.sv
// Shared types and defaults for the cache-to-memory bus responder.
package bus_pkg;

  localparam int BUS_ADDR_W = 9;
  localparam int BUS_DATA_W = 8;

  typedef logic [BUS_ADDR_W-1:0] addr_t;
  typedef logic [BUS_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Width of an initiator index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting initiator at or above rr_ptr, wrapping.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [id_w(NUM_REQ)-1:0]    rr_ptr,
  output logic [id_w(NUM_REQ)-1:0]    id,
  output logic                        valid
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0] cand;

  // Scan candidates upward from rr_ptr and keep the first one that requests.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        id    = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus responder: arbitrates initiators, owns the memory array and answers each
// accepted request with a one-cycle grant after a fixed access latency.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int MEM_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t             state, state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               rw_q;
  logic               accept;
  logic               finish;
  logic               release_bus;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [DATA_W-1:0]  mem       [2**ADDR_W];

  // Unpack the flattened per-initiator buses so the winner can be indexed directly.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .id     (pick_id),
    .valid  (pick_valid)
  );

  assign busy = (state != IDLE);

  // Next-state and per-edge strobes: accept a request, complete it, release the bus.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    finish      = 1'b0;
    release_bus = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        release_bus = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops back to IDLE and thereby aborts any access.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latch, latency counter, grant pulse, read return and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rr_ptr  <= '0;
      grant   <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        id_q    <= pick_id;
        addr_q  <= addr_arr[pick_id];
        wdata_q <= wdata_arr[pick_id];
        rw_q    <= rw[pick_id];
        cnt     <= CNT_W'(MEM_LATENCY - 1);
      end
      if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        grant <= NUM_REQ'(1) << id_q;
        if (!rw_q) rdata <= mem[addr_q];
      end
      if (release_bus) begin
        grant  <= '0;
        rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

  // Memory write port; commits only on the completing edge of a write.
  // NOTE: the memory array has no reset; contents survive reset and an aborted write never reaches it.
  always_ff @(posedge clk) begin
    if (finish && rw_q) mem[addr_q] <= wdata_q;
  end

endmodule
